// File: rtl/clock_divider_prog_if.sv
// -----------------------------------------------------------------------------
// clock_divider_prog_if
//   Groups the control/status signals of the programmable clock divider.
//   master : drives div_ratio, load, enable; observes clk_div, tick,
//            update_pending
//   slave  : the divider itself
//   Signals:
//     div_ratio      NUM_CH*CNT_W  ratio of channel i at [i*CNT_W +: CNT_W]
//     load           1             capture div_ratio into shadow registers
//     enable         NUM_CH        per-channel run enable
//     clk_div        NUM_CH        divided level per channel
//     tick           NUM_CH        one-cycle pulse at each period start
//     update_pending 1             some channel still holds an unapplied ratio
// -----------------------------------------------------------------------------
interface clock_divider_prog_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic [NUM_CH*CNT_W-1:0] div_ratio;
    logic                    load;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       tick;
    logic                    update_pending;

    modport master (
        output div_ratio, load, enable,
        input  clk_div, tick, update_pending
    );

    modport slave (
        input  div_ratio, load, enable,
        output clk_div, tick, update_pending
    );
endinterface

// File: rtl/clock_divider_prog.sv
// -----------------------------------------------------------------------------
// clock_divider_prog
//   Programmable multi-channel clock divider. Each channel divides clk by a
//   run-time ratio N (1..2^CNT_W-1): clk_div is high for (N+1)>>1 cycles and
//   low for the remainder, tick pulses in the first cycle of every period.
//   New ratios are captured into shadow registers on load and only take
//   effect at a period boundary, so clk_div never produces runt pulses.
//   Outputs are registered data signals, not clock nets.
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous active-high reset
//   bus    slave modport of clock_divider_prog_if (div_ratio, load, enable,
//          clk_div, tick, update_pending)
// -----------------------------------------------------------------------------
module clock_divider_prog #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_divider_prog_if.slave   bus
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_W = (CNT_W+1)'(1);

    logic [NUM_CH-1:0] pending_all;

    assign bus.update_pending = |pending_all;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] ratio_q;
        logic [CNT_W-1:0] shadow_q;
        logic             pend_q;
        logic             div_q;
        logic             tick_q;

        logic [CNT_W-1:0] ratio_in;
        logic [CNT_W-1:0] shadow_eff;
        logic [CNT_W-1:0] start_ratio;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W:0]   half_w;
        logic             pend_eff;
        logic             at_boundary;

        // A load in the same cycle as a boundary must win over the stored
        // shadow, so everything downstream uses the "effective" shadow/pending.
        always_comb begin
            ratio_in    = bus.div_ratio[i*CNT_W +: CNT_W];
            shadow_eff  = bus.load ? ratio_in : shadow_q;
            pend_eff    = bus.load | pend_q;
            start_ratio = pend_eff ? shadow_eff : ratio_q;
            cnt_inc     = cnt_q + ONE;
            half_w      = ({1'b0, ratio_q} + ONE_W) >> 1;
            // Ratio 1 has a boundary on every edge.
            at_boundary = (ratio_q <= ONE) || (cnt_q == ratio_q - ONE);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= ST_STOPPED;
                cnt_q    <= '0;
                ratio_q  <= '0;
                shadow_q <= '0;
                pend_q   <= 1'b0;
                div_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                shadow_q <= shadow_eff;
                pend_q   <= pend_eff;
                case (state_q)
                    ST_STOPPED: begin
                        cnt_q <= '0;
                        // Nothing to protect while stopped: apply at once.
                        if (pend_eff) begin
                            ratio_q <= shadow_eff;
                            pend_q  <= 1'b0;
                        end
                        if (bus.enable[i] && (start_ratio != '0)) begin
                            state_q <= ST_RUNNING;
                            div_q   <= 1'b1;
                            tick_q  <= 1'b1;
                        end else begin
                            div_q   <= 1'b0;
                            tick_q  <= 1'b0;
                        end
                    end
                    ST_RUNNING: begin
                        if (!bus.enable[i]) begin
                            state_q <= ST_STOPPED;
                            cnt_q   <= '0;
                            div_q   <= 1'b0;
                            tick_q  <= 1'b0;
                        end else if (at_boundary) begin
                            cnt_q <= '0;
                            if (pend_eff) begin
                                ratio_q <= shadow_eff;
                                pend_q  <= 1'b0;
                            end
                            if (pend_eff && (shadow_eff == '0)) begin
                                state_q <= ST_STOPPED;
                                div_q   <= 1'b0;
                                tick_q  <= 1'b0;
                            end else begin
                                div_q   <= 1'b1;
                                tick_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q  <= cnt_inc;
                            div_q  <= ({1'b0, cnt_inc} < half_w);
                            tick_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_STOPPED;
                        cnt_q   <= '0;
                        div_q   <= 1'b0;
                        tick_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.clk_div[i] = div_q;
        assign bus.tick[i]    = tick_q;
        assign pending_all[i] = pend_q;
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    clock_divider_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clock_divider_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [NUM_CH-1:0] div;
        logic [NUM_CH-1:0] tick;
        logic              upd;
    } exp_t;

    typedef struct {
        int ch;
        int ratio;
        int ticks;
        int highs;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position within the current period per channel.
    int m_run  [NUM_CH];
    int m_n    [NUM_CH];
    int m_pos  [NUM_CH];
    int m_sh   [NUM_CH];
    int m_pend [NUM_CH];

    logic [NUM_CH-1:0] last_div, last_tick;
    logic              last_upd, prev_upd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        int   sh_e;
        int   pe;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_run[c] = 0; m_n[c] = 0; m_pos[c] = 0; m_sh[c] = 0; m_pend[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sh_e = bus.load ? int'(bus.div_ratio[c*CNT_W +: CNT_W]) : m_sh[c];
                pe   = (bus.load || m_pend[c] != 0) ? 1 : 0;
                m_sh[c]   = sh_e;
                m_pend[c] = pe;
                if (m_run[c] == 0) begin
                    if (pe != 0) begin
                        m_n[c] = sh_e; m_pend[c] = 0;
                    end
                    m_pos[c] = 0;
                    m_run[c] = (bus.enable[c] && m_n[c] >= 1) ? 1 : 0;
                end else if (!bus.enable[c]) begin
                    m_run[c] = 0; m_pos[c] = 0;
                end else if (m_pos[c] == m_n[c] - 1) begin
                    if (pe != 0) begin
                        m_n[c] = sh_e; m_pend[c] = 0;
                    end
                    m_pos[c] = 0;
                    m_run[c] = (m_n[c] >= 1) ? 1 : 0;
                end else begin
                    m_pos[c]++;
                end
            end
        end
        e.upd = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            e.div[c]  = (m_run[c] != 0) && (m_pos[c] < (m_n[c] + 1) / 2);
            e.tick[c] = (m_run[c] != 0) && (m_pos[c] == 0);
            if (m_pend[c] != 0) e.upd = 1'b1;
        end
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        prev_upd  = last_upd;
        last_div  = bus.clk_div;
        last_tick = bus.tick;
        last_upd  = bus.update_pending;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            e = sbq.pop_front();
            check("sb_clk_div", 32'(last_div), 32'(e.div));
            check("sb_tick", 32'(last_tick), 32'(e.tick));
            check("sb_update_pending", 32'(last_upd), 32'(e.upd));
        end
    endtask

    task automatic set_ratios(input int r0, input int r1, input int r2, input int r3);
        bus.div_ratio = {CNT_W'(r3), CNT_W'(r2), CNT_W'(r1), CNT_W'(r0)};
    endtask

    task automatic load_step();
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    // Steps until tick[ch] is seen; n = steps taken, or limit on timeout.
    task automatic cycles_to_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_tick[ch] && n < limit);
    endtask

    vec_t tbl[NUM_CH];
    int   tick_cnt[NUM_CH];
    int   high_cnt[NUM_CH];
    int   n;

    initial begin
        tbl[0] = '{ch: 0, ratio: 2,  ticks: 24, highs: 24};
        tbl[1] = '{ch: 1, ratio: 3,  ticks: 16, highs: 32};
        tbl[2] = '{ch: 2, ratio: 4,  ticks: 12, highs: 24};
        tbl[3] = '{ch: 3, ratio: 16, ticks: 3,  highs: 24};

        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.enable    = '0;
        bus.div_ratio = '0;
        last_upd      = 1'b0;

        // 1. reset, then table-driven ratios and 48-cycle tick/high counts
        repeat (20) step();
        check("reset_clk_div", 32'(last_div), 32'h0);
        check("reset_tick", 32'(last_tick), 32'h0);
        check("reset_update_pending", 32'(last_upd), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            bus.div_ratio[tbl[i].ch*CNT_W +: CNT_W] = CNT_W'(tbl[i].ratio);
        load_step();
        check("stopped_apply_pending", 32'(last_upd), 32'h0);
        bus.enable = 4'hF;
        step();
        check("first_tick", 32'(last_tick), 32'hF);
        check("first_clk_div", 32'(last_div), 32'hF);
        for (int c = 0; c < NUM_CH; c++) begin
            tick_cnt[c] = int'(last_tick[c]);
            high_cnt[c] = int'(last_div[c]);
        end
        repeat (47) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                tick_cnt[c] += int'(last_tick[c]);
                high_cnt[c] += int'(last_div[c]);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("ticks48_ch%0d", tbl[i].ch), 32'(tick_cnt[tbl[i].ch]), 32'(tbl[i].ticks));
            check($sformatf("highs48_ch%0d", tbl[i].ch), 32'(high_cnt[tbl[i].ch]), 32'(tbl[i].highs));
        end

        // 2. ch3 at 16, load ratio 4 at cnt=5: period completes first
        n = 0;
        while (m_pos[3] != 5 && n < 32) begin
            step();
            n++;
        end
        check("reach_cnt5", 32'(m_pos[3]), 32'd5);
        set_ratios(2, 3, 4, 4);
        load_step();
        check("pending_after_load", 32'(last_upd), 32'h1);
        cycles_to_tick(3, 40, n);
        check("ch3_old_period_done", 32'(n), 32'd10);
        check("pending_before_boundary", 32'(prev_upd), 32'h1);
        check("pending_drops_at_boundary", 32'(last_upd), 32'h0);
        check("ch3_new_p0", 32'(last_div[3]), 32'h1);
        step(); check("ch3_new_p1", 32'(last_div[3]), 32'h1);
        step(); check("ch3_new_p2", 32'(last_div[3]), 32'h0);
        step(); check("ch3_new_p3", 32'(last_div[3]), 32'h0);
        step(); check("ch3_new_period_tick", 32'(last_tick[3]), 32'h1);

        // 3. ratio 0 on ch0, ratio 1 on ch1
        set_ratios(0, 1, 4, 4);
        load_step();
        repeat (20) step();
        for (int k = 0; k < 8; k++) begin
            step();
            check("ratio0_div", 32'(last_div[0]), 32'h0);
            check("ratio0_tick", 32'(last_tick[0]), 32'h0);
            check("ratio1_div", 32'(last_div[1]), 32'h1);
            check("ratio1_tick", 32'(last_tick[1]), 32'h1);
        end

        // 4. drop enable on ch0 (ratio 3) mid-high, then re-enable
        set_ratios(3, 1, 4, 4);
        load_step();
        check("ch0_start_tick", 32'(last_tick[0]), 32'h1);
        bus.enable = 4'hE;
        step();
        check("ch0_disable_div", 32'(last_div[0]), 32'h0);
        check("ch0_disable_tick", 32'(last_tick[0]), 32'h0);
        step();
        check("ch0_stays_low", 32'(last_div[0]), 32'h0);
        bus.enable = 4'hF;
        step();
        check("ch0_reenable_tick", 32'(last_tick[0]), 32'h1);
        check("ch0_reenable_div", 32'(last_div[0]), 32'h1);
        repeat (5) step();

        // 5. reset mid-run with load in the same cycle
        reset = 1'b1;
        set_ratios(5, 6, 7, 8);
        load_step();
        check("rst_load_div", 32'(last_div), 32'h0);
        check("rst_load_tick", 32'(last_tick), 32'h0);
        check("rst_load_pending", 32'(last_upd), 32'h0);
        reset = 1'b0;
        repeat (5) step();
        check("rst_load_ignored", 32'(last_div), 32'h0);

        // 6. two loads during a 20-cycle period, then load at the boundary
        bus.enable = 4'b0100;
        set_ratios(0, 0, 20, 0);
        load_step();
        check("ch2_start20", 32'(last_tick[2]), 32'h1);
        repeat (4) step();
        set_ratios(0, 0, 10, 0);
        load_step();
        repeat (2) step();
        set_ratios(0, 0, 6, 0);
        load_step();
        cycles_to_tick(2, 30, n);
        check("ch2_period20_done", 32'(n), 32'd12);
        cycles_to_tick(2, 30, n);
        check("ch2_last_load_wins", 32'(n), 32'd6);
        repeat (5) step();
        set_ratios(0, 0, 4, 0);
        load_step();
        check("boundary_load_tick", 32'(last_tick[2]), 32'h1);
        check("boundary_load_pending", 32'(last_upd), 32'h0);
        cycles_to_tick(2, 30, n);
        check("boundary_load_period", 32'(n), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
